// File: rtl/mem_bus_ctrl.sv
// MEM-stage bus controller: sequences RAM1 SRAM and UART accesses on the
// shared data bus, holding busy for the duration of each access.
module mem_bus_ctrl #(
    parameter int unsigned RAM_WAIT  = 1,
    parameter logic [15:0] UART_DATA = 16'hBF00,
    parameter logic [15:0] UART_STAT = 16'hBF01
) (
    input  logic        mci_clk,
    input  logic        mci_rst,
    input  logic        mci_req,
    input  logic [1:0]  mci_rwe,
    input  logic [15:0] mci_addr,
    input  logic [15:0] mci_wdata,
    output logic [15:0] mco_rdata,
    output logic        mco_done,
    output logic        mco_busy,
    output logic        mco_ram1_en,
    output logic        mco_ram1_we,
    output logic        mco_ram1_oe,
    output logic [15:0] mco_ram1_addr,
    output logic [15:0] mco_ram1_dout,
    output logic        mco_ram1_drive,
    input  logic [15:0] mci_ram1_din,
    input  logic        mci_uart_tbre,
    input  logic        mci_uart_tsre,
    input  logic        mci_uart_data_ready,
    output logic        mco_uart_wrn,
    output logic        mco_uart_rdn
);

    typedef enum logic [2:0] {
        IDLE, RAM_RD, RAM_WR, U_RD, U_WR, U_TBRE, U_TSRE, DONE
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(RAM_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic        oe_q, oe_d;
    logic        drive_q, drive_d;
    logic        wrn_q, wrn_d;
    logic        rdn_q, rdn_d;
    logic        acc_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        en_d    = en_q;
        we_d    = we_q;
        oe_d    = oe_q;
        drive_d = drive_q;
        wrn_d   = wrn_q;
        rdn_d   = rdn_q;
        acc_rd  = (mci_rwe == 2'b01);
        unique case (state_q)
            IDLE: begin
                if (mci_req && (mci_rwe == 2'b01 || mci_rwe == 2'b10)) begin
                    busy_d = 1'b1;
                    addr_d = mci_addr;
                    dout_d = mci_wdata;
                    cnt_d  = CNT_INIT;
                    if (mci_addr == UART_STAT) begin
                        state_d = DONE;
                        if (acc_rd)
                            rdata_d = {14'b0, mci_uart_data_ready,
                                       mci_uart_tbre & mci_uart_tsre};
                    end else if (mci_addr == UART_DATA) begin
                        if (acc_rd) begin
                            state_d = U_RD;
                        end else begin
                            state_d = U_WR;
                            drive_d = 1'b1;
                            wrn_d   = 1'b0;
                        end
                    end else if (acc_rd) begin
                        state_d = RAM_RD;
                        en_d    = 1'b0;
                        oe_d    = 1'b0;
                        drive_d = 1'b0;
                    end else begin
                        state_d = RAM_WR;
                        en_d    = 1'b0;
                        we_d    = 1'b0;
                        drive_d = 1'b1;
                    end
                end
            end
            RAM_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = mci_ram1_din;
                    en_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RAM_WR: begin
                // drive stays up into DONE so data outlasts the WE rise
                if (cnt_q == 4'd0) begin
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            U_RD: begin
                if (!rdn_q) begin
                    rdata_d = {8'b0, mci_ram1_din[7:0]};
                    rdn_d   = 1'b1;
                    state_d = DONE;
                end else if (mci_uart_data_ready) begin
                    rdn_d = 1'b0;
                end
            end
            U_WR: begin
                wrn_d   = 1'b1;
                state_d = U_TBRE;
            end
            U_TBRE: begin
                if (mci_uart_tbre)
                    state_d = U_TSRE;
            end
            U_TSRE: begin
                if (mci_uart_tsre)
                    state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                drive_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mci_clk) begin
        if (!mci_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'd0;
            addr_q  <= 16'd0;
            dout_q  <= 16'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            drive_q <= 1'b0;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            drive_q <= drive_d;
            wrn_q   <= wrn_d;
            rdn_q   <= rdn_d;
        end
    end

    assign mco_rdata      = rdata_q;
    assign mco_done       = done_q;
    assign mco_busy       = busy_q;
    assign mco_ram1_en    = en_q;
    assign mco_ram1_we    = we_q;
    assign mco_ram1_oe    = oe_q;
    assign mco_ram1_addr  = addr_q;
    assign mco_ram1_dout  = dout_q;
    assign mco_ram1_drive = drive_q;
    assign mco_uart_wrn   = wrn_q;
    assign mco_uart_rdn   = rdn_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a small SRAM model on the shared bus.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  rwe;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        busy;
    logic        en, we, oe;
    logic [15:0] raddr;
    logic [15:0] dout;
    logic        drive;
    logic [15:0] din;
    logic        tbre, tsre, dr;
    logic        wrn, rdn;
    logic [15:0] uart_din;
    logic [15:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign din = drive ? dout :
                 ((!en && !oe) ? mem[raddr[7:0]] : uart_din);

    always @(posedge clk)
        if (!en && !we) mem[raddr[7:0]] <= dout;

    mem_bus_ctrl dut (
        .mci_clk(clk), .mci_rst(rst), .mci_req(req), .mci_rwe(rwe),
        .mci_addr(addr), .mci_wdata(wdata), .mco_rdata(rdata),
        .mco_done(done), .mco_busy(busy), .mco_ram1_en(en),
        .mco_ram1_we(we), .mco_ram1_oe(oe), .mco_ram1_addr(raddr),
        .mco_ram1_dout(dout), .mco_ram1_drive(drive),
        .mci_ram1_din(din), .mci_uart_tbre(tbre),
        .mci_uart_tsre(tsre), .mci_uart_data_ready(dr),
        .mco_uart_wrn(wrn), .mco_uart_rdn(rdn)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({en, we, oe, wrn, rdn} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=11111", {en, we, oe, wrn, rdn});
        end
        checks++;
        if ({drive, done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=000", {drive, done, busy});
        end
        checks++;
        if ({rdata, raddr, dout} !== 48'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {rdata, raddr, dout});
        end
        rst = 1'b1;
    endtask

    task automatic test_ram;
        req = 1'b1; rwe = 2'b10; addr = 16'h4000; wdata = 16'h1234;
        tick();
        checks++;
        if ({busy, en, we, oe, drive, done} !== 6'b100110) begin
            failures++;
            $display("FAIL ram_wr_k got=%b exp=100110", {busy, en, we, oe, drive, done});
        end
        checks++;
        if (dout !== 16'h1234 || raddr !== 16'h4000) begin
            failures++;
            $display("FAIL ram_wr_latch got=%h/%h exp=1234/4000", dout, raddr);
        end
        addr = 16'h0000; wdata = 16'hFFFF;
        tick();
        checks++;
        if ({busy, en, we, drive, done} !== 5'b11110) begin
            failures++;
            $display("FAIL ram_wr_k1 got=%b exp=11110", {busy, en, we, drive, done});
        end
        tick();
        checks++;
        if ({done, busy, drive} !== 3'b100) begin
            failures++;
            $display("FAIL ram_wr_done got=%b exp=100", {done, busy, drive});
        end
        req = 1'b0;
        tick();
        req = 1'b1; rwe = 2'b01; addr = 16'h4000;
        tick();
        checks++;
        if ({en, oe, we, drive, busy} !== 5'b00101) begin
            failures++;
            $display("FAIL ram_rd_k got=%b exp=00101", {en, oe, we, drive, busy});
        end
        tick();
        checks++;
        if (rdata !== 16'h1234 || oe !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ram_rd_k1 got=%h oe=%b done=%b exp=1234/1/0", rdata, oe, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || rdata !== 16'h1234) begin
            failures++;
            $display("FAIL ram_rd_done got=%b/%h exp=1/1234", done, rdata);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_status;
        tbre = 1'b1; tsre = 1'b1; dr = 1'b1;
        req = 1'b1; rwe = 2'b01; addr = 16'hBF01;
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || rdata !== 16'h0003) begin
            failures++;
            $display("FAIL stat_k got=%b/%b/%h exp=1/0/0003", busy, done, rdata);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rdata !== 16'h0003) begin
            failures++;
            $display("FAIL stat_done got=%b/%b/%h exp=1/0/0003", done, busy, rdata);
        end
        req = 1'b0; dr = 1'b0;
        tick();
    endtask

    task automatic test_uart_write;
        int wrn_low = 0;
        int done_at = -1;
        int busy_at = -1;
        int en_bad = 0;
        tbre = 1'b0; tsre = 1'b0;
        req = 1'b1; rwe = 2'b10; addr = 16'hBF00; wdata = 16'h0041;
        for (int i = 0; i < 16; i++) begin
            tbre = (i >= 5);
            tsre = (i >= 8);
            tick();
            if (!wrn) wrn_low++;
            if (!en || !rdn) en_bad++;
            if (done && done_at < 0) done_at = i;
            if (!busy && busy_at < 0) busy_at = i;
            if (i == 0 && dout !== 16'h0041) en_bad++;
            if (done) req = 1'b0;
        end
        checks++;
        if (wrn_low !== 1) begin
            failures++;
            $display("FAIL uwr_wrn_cycles got=%0d exp=1", wrn_low);
        end
        checks++;
        if (done_at !== 9 || busy_at !== 9) begin
            failures++;
            $display("FAIL uwr_timing got=done@%0d busy0@%0d exp=9/9", done_at, busy_at);
        end
        checks++;
        if (en_bad !== 0) begin
            failures++;
            $display("FAIL uwr_en_rdn_dout got=%0d bad exp=0", en_bad);
        end
    endtask

    task automatic test_uart_read;
        int rdn_low = 0;
        int rdn_at = -1;
        int done_at = -1;
        int bad = 0;
        logic [15:0] rd_at_done = 16'h0;
        uart_din = 16'hAB55; dr = 1'b0;
        req = 1'b1; rwe = 2'b01; addr = 16'hBF00;
        for (int i = 0; i < 16; i++) begin
            dr = (i >= 10);
            tick();
            if (!rdn) begin
                rdn_low++;
                if (rdn_at < 0) rdn_at = i;
            end
            if (!en || !wrn) bad++;
            if (i < 12 && !busy) bad++;
            if (done && done_at < 0) begin
                done_at = i;
                rd_at_done = rdata;
            end
            if (done) begin req = 1'b0; dr = 1'b0; end
        end
        dr = 1'b0;
        checks++;
        if (rdn_low !== 1 || rdn_at !== 10) begin
            failures++;
            $display("FAIL urd_rdn got=%0d@%0d exp=1@10", rdn_low, rdn_at);
        end
        checks++;
        if (done_at !== 12 || rd_at_done !== 16'h0055) begin
            failures++;
            $display("FAIL urd_done got=@%0d %h exp=@12 0055", done_at, rd_at_done);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL urd_hold got=%0d bad exp=0", bad);
        end
    endtask

    task automatic test_reset_mid;
        tbre = 1'b0; tsre = 1'b0;
        req = 1'b1; rwe = 2'b10; addr = 16'hBF00; wdata = 16'h0042;
        tick();
        tick();
        tick();
        rst = 1'b0; req = 1'b0;
        tick();
        checks++;
        if ({en, we, oe, wrn, rdn, busy, done, drive} !== 8'b11111000) begin
            failures++;
            $display("FAIL rst_tbre got=%b exp=11111000", {en, we, oe, wrn, rdn, busy, done, drive});
        end
        rst = 1'b1; tbre = 1'b1; tsre = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_tbre_after got=%b%b exp=00", done, busy);
        end
        req = 1'b1; rwe = 2'b01; addr = 16'h4000;
        tick();
        rst = 1'b0; req = 1'b0;
        tick();
        checks++;
        if ({en, we, oe, busy, done, rdata} !== {5'b11100, 16'h0}) begin
            failures++;
            $display("FAIL rst_ramrd got=%b%b%b%b%b %h exp=11100 0000", en, we, oe, busy, done, rdata);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rst_ramrd_after got=%b exp=0", done);
        end
        req = 1'b1; rwe = 2'b01; addr = 16'h4000;
        tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || rdata !== 16'h1234) begin
            failures++;
            $display("FAIL rst_recover got=%b/%h exp=1/1234", done, rdata);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        req = 1'b1; rwe = 2'b00; addr = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            rwe = (i == 2) ? 2'b11 : 2'b00;
            tick();
            if (busy || !en || !wrn || !rdn || done) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rwe_noacc got=%0d bad exp=0", bad);
        end
        tbre = 1'b1; tsre = 1'b1; dr = 1'b0;
        rwe = 2'b01; addr = 16'hBF01;
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || rdata !== 16'h0001) begin
            failures++;
            $display("FAIL b2b_first got=%b/%h exp=1/0001", done, rdata);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got=%b%b exp=10", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got=%b%b exp=10", done, busy);
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst = 1'b0; req = 1'b0; rwe = 2'b00; addr = 16'h0; wdata = 16'h0;
        tbre = 1'b0; tsre = 1'b0; dr = 1'b0; uart_din = 16'h0;
        @(negedge clk);
        test_reset();
        test_ram();
        test_status();
        test_uart_write();
        test_uart_read();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
